// File: rtl/mips_alu_pkg.sv
// Shared opcodes, FSM state type and decode helper for the MIPS execute unit.
package mips_alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_SLL   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_MFHI  = 4'b1110;
  localparam logic [3:0] ALU_MFLO  = 4'b1111;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

  // Multiply/divide codes all live in the 10xx group; bit 1 selects divide,
  // bit 0 selects the unsigned flavour.
  function automatic logic is_mdu_op(input logic [3:0] code);
    return code[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/mips_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring-division
// step per cycle on operand magnitudes, with sign correction applied to the
// combinational hi/lo results that the top level captures in its FIX state.
module mips_mdu_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             run_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               remNeg_q, remNeg_d;
  logic               bZero_q, bZero_d;

  logic [WIDTH-1:0]   aMag, bMag;
  logic [WIDTH:0]     mulAddend, mulSum;
  logic [WIDTH:0]     divShift, divDiff;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quo, rem;

  // Operand magnitudes for signed ops; the most-negative value maps onto
  // itself, which reads correctly as an unsigned magnitude.
  always_comb begin
    aMag = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    bMag = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // One iteration step: multiply keeps {partial, multiplier} in acc and
  // shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
  always_comb begin
    mulAddend = acc_q[0] ? {1'b0, opnd_q} : '0;
    mulSum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mulAddend;
    divShift  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    divDiff   = divShift - {1'b0, opnd_q};
  end

  // Next-state for the iteration registers: load on start, step while running.
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_d    = neg_q;
    remNeg_d = remNeg_q;
    bZero_d  = bZero_q;
    if (start_i) begin
      cnt_d    = '0;
      div_d    = is_div_i;
      neg_d    = is_signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      remNeg_d = is_signed_i && a_i[WIDTH-1];
      bZero_d  = (b_i == '0);
      if (is_div_i) begin
        acc_d  = {{WIDTH{1'b0}}, aMag};
        opnd_d = bMag;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, bMag};
        opnd_d = aMag;
      end
    end else if (run_i) begin
      cnt_d = cnt_q + CW'(1);
      if (div_q) begin
        acc_d = {(divDiff[WIDTH] ? divShift[WIDTH-1:0] : divDiff[WIDTH-1:0]),
                 acc_q[WIDTH-2:0], ~divDiff[WIDTH]};
      end else begin
        acc_d = {mulSum, acc_q[WIDTH-1:1]};
      end
    end
  end

  // Iteration state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      remNeg_q <= 1'b0;
      bZero_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      remNeg_q <= remNeg_d;
      bZero_q  <= bZero_d;
    end
  end

  // Sign-corrected results; divide by zero forces an all-ones quotient while
  // the remainder path naturally reproduces the dividend.
  always_comb begin
    prodFix = neg_q ? -acc_q : acc_q;
    quo     = acc_q[WIDTH-1:0];
    rem     = acc_q[2*WIDTH-1:WIDTH];
    if (div_q) begin
      hi_o = remNeg_q ? -rem : rem;
      lo_o = bZero_q ? '1 : (neg_q ? -quo : quo);
    end else begin
      hi_o = prodFix[2*WIDTH-1:WIDTH];
      lo_o = prodFix[WIDTH-1:0];
    end
  end

  assign done_o = run_i && (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mips_alu_mdu.sv
// EX-stage execute unit: single-cycle ALU, iterative mult/div with HI/LO,
// registered result and a valid/ready handshake that stalls on long ops.
module mips_alu_mdu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             accept, isMdu, start, run, mduDone;
  logic [WIDTH-1:0] mduHi, mduLo;
  logic [WIDTH-1:0] sum, diff, aluRes;
  logic             aluOvf;
  logic [WIDTH-1:0] aluOut_q, aluOut_d, hi_q, hi_d, lo_q, lo_d;
  logic             ovf_q, ovf_d, outValid_q, outValid_d;

  assign accept = in_valid && in_ready;
  assign isMdu  = is_mdu_op(alu_ctl);
  assign start  = accept && isMdu;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: launch on an accepted mult/div, fix up after the last step.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = alu_ctl[1] ? DIV : MUL;
      MUL,
      DIV:     if (mduDone) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: handshake, busy flag and iteration enable.
  always_comb begin
    in_ready = (state_q == IDLE);
    busy     = (state_q != IDLE);
    run      = (state_q == MUL) || (state_q == DIV);
  end

  mips_mdu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .is_div_i   (alu_ctl[1]),
    .is_signed_i(~alu_ctl[0]),
    .a_i        (a),
    .b_i        (b),
    .run_i      (run),
    .done_o     (mduDone),
    .hi_o       (mduHi),
    .lo_o       (mduLo)
  );

  // Combinational single-cycle ALU and signed-overflow detection.
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    aluRes = '0;
    aluOvf = 1'b0;
    case (alu_ctl)
      ALU_AND:  aluRes = a & b;
      ALU_OR:   aluRes = a | b;
      ALU_XOR:  aluRes = a ^ b;
      ALU_NOR:  aluRes = ~(a | b);
      ALU_ADD: begin
        aluRes = sum;
        aluOvf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        aluRes = diff;
        aluOvf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT:  aluRes = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL:  aluRes = b << shamt;
      ALU_SRL:  aluRes = b >> shamt;
      ALU_SRA:  aluRes = $signed(b) >>> shamt;
      ALU_MFHI: aluRes = hi_q;
      ALU_MFLO: aluRes = lo_q;
      default:  aluRes = '0;
    endcase
  end

  // Output register next state: FIX commits hi/lo, accepts load the ALU result.
  always_comb begin
    aluOut_d   = aluOut_q;
    ovf_d      = ovf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    outValid_d = 1'b0;
    if (state_q == FIX) begin
      hi_d       = mduHi;
      lo_d       = mduLo;
      aluOut_d   = mduLo;
      outValid_d = 1'b1;
    end else if (accept) begin
      ovf_d = isMdu ? 1'b0 : aluOvf;
      if (!isMdu) begin
        aluOut_d   = aluRes;
        outValid_d = 1'b1;
      end
    end
  end

  // Output registers; reset aborts any pending result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      aluOut_q   <= '0;
      ovf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      outValid_q <= 1'b0;
    end else begin
      aluOut_q   <= aluOut_d;
      ovf_q      <= ovf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      outValid_q <= outValid_d;
    end
  end

  assign alu_out   = aluOut_q;
  assign overflow  = ovf_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign out_valid = outValid_q;
  assign zero      = (aluOut_q == '0);

endmodule

// File: tb/tb_mips_alu_mdu.sv
// Directed self-checking bench: an 8-bit instance for the functional vectors
// and a 32-bit instance for the reset-abort scenario.
module tb_mips_alu_mdu;
  import mips_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, v8, ir8, ov8, z8, ovf8, bsy8;
  logic [3:0] ctl8;
  logic [7:0] a8, b8, out8, hi8, lo8;
  logic [2:0] sh8;

  logic        rst32, v32, ir32, ov32, z32, ovf32, bsy32;
  logic [3:0]  ctl32;
  logic [31:0] a32, b32, out32, hi32, lo32;
  logic [4:0]  sh32;

  int testCount = 0;
  int failCount = 0;
  int busyCycles, edgeIdx, seen;

  mips_alu_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .in_valid(v8), .in_ready(ir8), .alu_ctl(ctl8),
    .a(a8), .b(b8), .shamt(sh8), .out_valid(ov8), .alu_out(out8), .zero(z8),
    .overflow(ovf8), .hi(hi8), .lo(lo8), .busy(bsy8)
  );

  mips_alu_mdu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(rst32), .in_valid(v32), .in_ready(ir32), .alu_ctl(ctl32),
    .a(a32), .b(b32), .shamt(sh32), .out_valid(ov32), .alu_out(out32), .zero(z32),
    .overflow(ovf32), .hi(hi32), .lo(lo32), .busy(bsy32)
  );

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one op to the 8-bit unit for a single accept edge.
  task automatic applyStimulus8(input logic [3:0] ctl, input logic [7:0] a,
                                input logic [7:0] b, input logic [2:0] sh);
    v8 = 1'b1; ctl8 = ctl; a8 = a; b8 = b; sh8 = sh;
    @(posedge clk); #1;
    v8 = 1'b0;
  endtask

  // Present one op to the 32-bit unit for a single accept edge.
  task automatic applyStimulus32(input logic [3:0] ctl, input logic [31:0] a,
                                 input logic [31:0] b);
    v32 = 1'b1; ctl32 = ctl; a32 = a; b32 = b; sh32 = '0;
    @(posedge clk); #1;
    v32 = 1'b0;
  endtask

  // Wait (bounded) for the 8-bit unit's result pulse.
  task automatic waitDone8(input string tag);
    int n = 0;
    while (!ov8 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(ov8), 32'd1);
  endtask

  // Wait (bounded) for the 32-bit unit's result pulse.
  task automatic waitDone32(input string tag);
    int n = 0;
    while (!ov32 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(tag, 32'(ov32), 32'd1);
  endtask

  initial begin
    rst8 = 1'b1; rst32 = 1'b1;
    v8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0; sh8 = '0;
    v32 = 1'b0; ctl32 = '0; a32 = '0; b32 = '0; sh32 = '0;
    #2;
    checkOutput("rst alu_out", 32'(out8), 32'h0);
    checkOutput("rst zero", 32'(z8), 32'd1);
    checkOutput("rst overflow", 32'(ovf8), 32'd0);
    checkOutput("rst out_valid", 32'(ov8), 32'd0);
    checkOutput("rst hi", 32'(hi8), 32'h0);
    checkOutput("rst lo", 32'(lo8), 32'h0);
    checkOutput("rst busy", 32'(bsy8), 32'd0);
    checkOutput("rst in_ready", 32'(ir8), 32'd1);
    checkOutput("rst32 in_ready", 32'(ir32), 32'd1);
    @(posedge clk); #1;
    rst8 = 1'b0; rst32 = 1'b0;

    // Add with signed overflow, then sub to zero back to back.
    applyStimulus8(ALU_ADD, 8'h7F, 8'h01, 3'd0);
    checkOutput("add valid", 32'(ov8), 32'd1);
    checkOutput("add result", 32'(out8), 32'h80);
    checkOutput("add overflow", 32'(ovf8), 32'd1);
    checkOutput("add zero", 32'(z8), 32'd0);
    applyStimulus8(ALU_SUB, 8'h05, 8'h05, 3'd0);
    checkOutput("sub valid", 32'(ov8), 32'd1);
    checkOutput("sub result", 32'(out8), 32'h00);
    checkOutput("sub zero", 32'(z8), 32'd1);
    checkOutput("sub overflow", 32'(ovf8), 32'd0);
    applyStimulus8(ALU_SUB, 8'h80, 8'h01, 3'd0);
    checkOutput("sub ovf result", 32'(out8), 32'h7F);
    checkOutput("sub ovf flag", 32'(ovf8), 32'd1);
    @(posedge clk); #1;
    checkOutput("valid pulse ends", 32'(ov8), 32'd0);

    // Signed mult -3*5 with in_valid held high throughout.
    v8 = 1'b1; ctl8 = ALU_MULT; a8 = 8'hFD; b8 = 8'h05; sh8 = '0;
    @(posedge clk); #1;
    ctl8 = ALU_ADD; a8 = 8'h01; b8 = 8'h02;
    checkOutput("mult in_ready low", 32'(ir8), 32'd0);
    busyCycles = bsy8 ? 1 : 0;
    edgeIdx = 0;
    while (!ov8 && edgeIdx < 20) begin
      @(posedge clk); #1;
      edgeIdx++;
      if (!ov8 && bsy8) busyCycles++;
    end
    checkOutput("mult latency", 32'(edgeIdx), 32'd9);
    checkOutput("mult busy cycles", 32'(busyCycles), 32'd9);
    checkOutput("mult hi", 32'(hi8), 32'hFF);
    checkOutput("mult lo", 32'(lo8), 32'hF1);
    checkOutput("mult alu_out", 32'(out8), 32'hF1);
    checkOutput("mult in_ready back", 32'(ir8), 32'd1);
    @(posedge clk); #1;
    v8 = 1'b0;
    checkOutput("held add valid", 32'(ov8), 32'd1);
    checkOutput("held add result", 32'(out8), 32'h03);
    checkOutput("hi kept by add", 32'(hi8), 32'hFF);

    // Divides, then mflo straight after completion.
    applyStimulus8(ALU_DIVU, 8'd100, 8'd7, 3'd0);
    waitDone8("divu done");
    checkOutput("divu lo", 32'(lo8), 32'h0E);
    checkOutput("divu hi", 32'(hi8), 32'h02);
    applyStimulus8(ALU_DIV, 8'hF9, 8'h02, 3'd0);
    waitDone8("div done");
    checkOutput("div lo", 32'(lo8), 32'hFD);
    checkOutput("div hi", 32'(hi8), 32'hFF);
    applyStimulus8(ALU_MFLO, 8'h00, 8'h00, 3'd0);
    checkOutput("mflo result", 32'(out8), 32'hFD);
    applyStimulus8(ALU_MFHI, 8'h00, 8'h00, 3'd0);
    checkOutput("mfhi result", 32'(out8), 32'hFF);
    applyStimulus8(ALU_DIV, 8'h80, 8'hFF, 3'd0);
    waitDone8("div min done");
    checkOutput("div min lo", 32'(lo8), 32'h80);
    checkOutput("div min hi", 32'(hi8), 32'h00);
    applyStimulus8(ALU_DIV, 8'hF9, 8'h00, 3'd0);
    waitDone8("div by0 done");
    checkOutput("div by0 hi", 32'(hi8), 32'hF9);
    checkOutput("div by0 lo", 32'(lo8), 32'hFF);
    applyStimulus8(ALU_DIVU, 8'h2A, 8'h00, 3'd0);
    waitDone8("divu by0 done");
    checkOutput("divu by0 hi", 32'(hi8), 32'h2A);
    checkOutput("divu by0 lo", 32'(lo8), 32'hFF);

    // Shifts and compare.
    applyStimulus8(ALU_SRA, 8'h00, 8'h80, 3'd3);
    checkOutput("sra result", 32'(out8), 32'hF0);
    applyStimulus8(ALU_SRL, 8'h00, 8'h80, 3'd3);
    checkOutput("srl result", 32'(out8), 32'h10);
    applyStimulus8(ALU_SLL, 8'h00, 8'h81, 3'd1);
    checkOutput("sll result", 32'(out8), 32'h02);
    applyStimulus8(ALU_SLT, 8'hFF, 8'h01, 3'd0);
    checkOutput("slt result", 32'(out8), 32'h01);
    applyStimulus8(ALU_SLT, 8'h01, 8'hFF, 3'd0);
    checkOutput("slt false", 32'(out8), 32'h00);

    // Back-to-back logic ops, one result per cycle.
    applyStimulus8(ALU_AND, 8'hCC, 8'hAA, 3'd0);
    checkOutput("and valid", 32'(ov8), 32'd1);
    checkOutput("and result", 32'(out8), 32'h88);
    applyStimulus8(ALU_OR, 8'hCC, 8'hAA, 3'd0);
    checkOutput("or valid", 32'(ov8), 32'd1);
    checkOutput("or result", 32'(out8), 32'hEE);
    applyStimulus8(ALU_NOR, 8'hCC, 8'hAA, 3'd0);
    checkOutput("nor valid", 32'(ov8), 32'd1);
    checkOutput("nor result", 32'(out8), 32'h11);
    applyStimulus8(ALU_XOR, 8'hCC, 8'hAA, 3'd0);
    checkOutput("xor valid", 32'(ov8), 32'd1);
    checkOutput("xor result", 32'(out8), 32'h66);
    checkOutput("hi kept by alu", 32'(hi8), 32'h2A);
    checkOutput("lo kept by alu", 32'(lo8), 32'hFF);

    // 32-bit: full multu, then abort a mult with reset.
    applyStimulus32(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone32("multu32 done");
    checkOutput("multu32 hi", hi32, 32'hFFFF_FFFE);
    checkOutput("multu32 lo", lo32, 32'h0000_0001);
    applyStimulus32(ALU_MULT, 32'd1234, 32'd5678);
    repeat (4) begin
      @(posedge clk); #1;
    end
    checkOutput("mult32 busy", 32'(bsy32), 32'd1);
    rst32 = 1'b1;
    #1;
    checkOutput("abort busy", 32'(bsy32), 32'd0);
    checkOutput("abort in_ready", 32'(ir32), 32'd1);
    checkOutput("abort hi", hi32, 32'h0);
    checkOutput("abort lo", lo32, 32'h0);
    checkOutput("abort out_valid", 32'(ov32), 32'd0);
    @(posedge clk); #1;
    rst32 = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    checkOutput("no result after abort", 32'(seen), 32'd0);
    applyStimulus32(ALU_ADD, 32'd2, 32'd3);
    checkOutput("add32 valid", 32'(ov32), 32'd1);
    checkOutput("add32 result", out32, 32'd5);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
